// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Issue/writeback stage around a 16-bit combinational ALU. Takes one
//   instruction at a time over a valid/ready handshake. It reads the operands
//   from an internal 16x16 register file. It presents the operands to the ALU
//   one cycle before the control code changes, holds the control code for
//   EXEC_CYCLES cycles, and then writes the result back to the register file.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    instruction handshake; ready only in IDLE
//   in_instr             [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt / [7:0] imm8
//   alu_ctrl/a/b         registered drive to the ALU
//   alu_result           ALU output, sampled at the end of WB
//   busy, retire         status; retire pulses during WB of a retiring instr
//   retire_cnt           wrapping count of retired instructions
//   err                  sticky illegal-opcode flag
//   dbg_addr/dbg_data    combinational register-file read port
module alu_issue_unit #(
    parameter int DATA_W      = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              retire,
    output logic [15:0]       retire_cnt,
    output logic              err,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, SETTLE, EXEC, WB} state_t;

    state_t            state, state_nxt;
    logic [15:0]       instr;
    logic [3:0]        exec_cnt;
    logic [DATA_W-1:0] rf [16];

    logic [3:0]        op, rd;
    logic              is_alu, is_ldi, is_ill, wb_we;
    logic [DATA_W-1:0] wb_data;

    assign op     = instr[15:12];
    assign rd     = instr[11:8];
    assign is_ldi = (op == 4'hE);
    assign is_ill = (op == 4'hF);
    assign is_alu = (op != 4'h0) && !is_ldi && !is_ill;

    // A write to r0 is dropped here, so r0 keeps its reset value of zero.
    assign wb_we   = (state == WB) && (is_alu || is_ldi) && (rd != 4'h0);
    assign wb_data = is_ldi ? DATA_W'(instr[7:0]) : alu_result;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign retire   = (state == WB) && !is_ill;
    assign dbg_data = rf[dbg_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SETTLE;
            SETTLE:  state_nxt = EXEC;
            EXEC:    if (exec_cnt == 4'd0) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            instr      <= '0;
            exec_cnt   <= '0;
            alu_ctrl   <= 4'b0000;
            alu_a      <= '0;
            alu_b      <= '0;
            retire_cnt <= '0;
            err        <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    // Operands come straight from the incoming fields, so they
                    // reflect any write completed on the previous WB edge.
                    instr <= in_instr;
                    alu_a <= rf[in_instr[7:4]];
                    alu_b <= rf[in_instr[3:0]];
                end
                SETTLE: begin
                    // Operands have now been stable for a full cycle.
                    if (is_alu) alu_ctrl <= op;
                    exec_cnt <= 4'(EXEC_CYCLES - 1);
                end
                EXEC: if (exec_cnt != 4'd0) exec_cnt <= exec_cnt - 4'd1;
                WB: begin
                    // Return to 0000 so back-to-back identical ops still give
                    // the ALU a control transition.
                    alu_ctrl <= 4'b0000;
                    if (is_ill) err <= 1'b1;
                    else        retire_cnt <= retire_cnt + 16'd1;
                    if (wb_we)  rf[rd] <= wb_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
    localparam int DATA_W = 16;
    localparam int EC     = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_instr = '0;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              busy, retire, err;
    logic [15:0]       retire_cnt;
    logic [3:0]        dbg_addr, stim_addr = '0, mon_addr = '0;
    logic              mon_active = 1'b0;
    logic [DATA_W-1:0] dbg_data;

    alu_issue_unit #(.DATA_W(DATA_W), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy), .retire(retire),
        .retire_cnt(retire_cnt), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Simple ALU stand-in: 0001 add, 0010 sub, others xor.
    always_comb begin
        case (alu_ctrl)
            4'h1:    alu_result = alu_a + alu_b;
            4'h2:    alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    assign dbg_addr = mon_active ? mon_addr : stim_addr;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] val;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0, n_total = 0, n_push = 0, n_pulse = 0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic push(input logic [3:0] rd, input logic [15:0] val);
        exp_cnt++;
        n_push++;
        exp_q.push_back('{rd, val, exp_cnt});
    endtask

    // Monitor: on every retire pulse pop the expectation, then read the
    // destination register back once the write edge has passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire) begin
                n_pulse++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cnt_during_wb", retire_cnt, e.cnt - 16'd1);
                    @(negedge clk);
                    mon_addr   = e.rd;
                    mon_active = 1'b1;
                    #1;
                    chk($sformatf("rf[%0d]", e.rd), dbg_data, e.val);
                    chk("retire_cnt", retire_cnt, e.cnt);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic issue(input logic [15:0] ins);
        int n = 0;
        wait_idle();
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("busy_len", n, 2 + EC);
    endtask

    task automatic rd_dbg(input logic [3:0] a, input logic [15:0] expv);
        @(negedge clk);
        #3 stim_addr = a;
        #1 chk($sformatf("dbg_r%0d", a), dbg_data, expv);
    endtask

    initial begin
        logic [3:0] seq [6];
        int acc;
        int t;
        seq = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_retire", retire, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_ab", {alu_a, alu_b}, 0);
        for (int i = 0; i < 16; i++) begin
            stim_addr = 4'(i);
            #1 chk($sformatf("rst_r%0d", i), dbg_data, 0);
        end

        // ldi r1,5; ldi r2,3; add r3 = r1 + r2
        push(4'd1, 16'h0005); issue(16'hE105);
        push(4'd2, 16'h0003); issue(16'hE203);
        push(4'd3, 16'h0008); issue(16'h1312);

        // Back-to-back sub r4, r5 with control-sequence trace
        wait_idle();
        push(4'd4, 16'h0002);
        push(4'd5, 16'h0002);
        in_valid = 1'b1;
        in_instr = 16'h2412;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("ctrl_seq%0d", k), alu_ctrl, seq[k]);
            if (k == 3) in_instr = 16'h2512;
            if (k == 4) in_valid = 1'b0;
        end
        wait_idle();

        // r0 write dropped; add r6 = r0 + r1
        push(4'd0, 16'h0000); issue(16'hE0FF);
        push(4'd6, 16'h0005); issue(16'h1601);

        // Illegal opcode: sticky err, no write, no retire
        issue(16'hF712);
        chk("err_set", err, 1);
        rd_dbg(4'd7, 16'h0000);
        push(4'd7, 16'h0011); issue(16'hE711);
        chk("err_sticky", err, 1);

        // in_valid held for 10 cycles: accepts only in IDLE cycles
        wait_idle();
        repeat (3) push(4'd8, 16'h0022);
        acc = 0;
        in_valid = 1'b1;
        in_instr = 16'hE822;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_ready%0d", i), in_ready, (i % 4) == 0);
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_accepts", acc, 3);

        // Drain scoreboard
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        chk("pulses", n_pulse, n_push);
        chk("cnt_final", retire_cnt, exp_cnt);

        // Reset in the middle of EXEC discards the instruction
        wait_idle();
        in_valid = 1'b1;
        in_instr = 16'hE933;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_exec_ctrl", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ctrl", alu_ctrl, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cnt", retire_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        #1 chk("post_rst_ready", in_ready, 1);
        rd_dbg(4'd9, 16'h0000);
        rd_dbg(4'd1, 16'h0000);

        // Unit works normally after reset
        push(4'd9, 16'h0044); issue(16'hE944);
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain2", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Issue/writeback stage wrapped around the 16-bit combinational ALU.
- Accepts 16-bit ALU instructions over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives the ALU's control and operand inputs with a strict settle-then-trigger sequence, then writes the ALU result back to the register file.
- One instruction is in flight at a time, so no forwarding or hazard logic is needed.

Parameters:
- DATA_W, 16, datapath width; must match the ALU operand width.
- EXEC_CYCLES, 1, cycles alu_ctrl is held at the opcode before writeback; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit can accept an instruction (high only in IDLE).
- in_instr  in  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt; for op 1110, [7:0] is imm8.
- alu_ctrl  out  4  registered; drives the ALU control input.
- alu_a  out  DATA_W  registered; drives ALU operand 1.
- alu_b  out  DATA_W  registered; drives ALU operand 2.
- alu_result  in  DATA_W  ALU output.
- busy  out  1  high in any state other than IDLE.
- retire  out  1  one-cycle pulse in the WB cycle of a retiring instruction.
- retire_cnt  out  16  count of retired instructions; wraps 16'hFFFF -> 0.
- err  out  1  sticky illegal-opcode flag.
- dbg_addr  in  4  debug register-file read address.
- dbg_data  out  DATA_W  combinational rf[dbg_addr].

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE, all 16 registers=0, alu_ctrl=4'b0000, alu_a=alu_b=0.
  - retire=0, retire_cnt=0, err=0, busy=0.
  - in_ready=1 once rst_n is high.
  - An instruction in flight is discarded; no write occurs.
- Register file:
  - r0 reads as 0; writes to r0 are dropped.
  - Reads are asynchronous.
  - One write port, used only on the edge that ends WB.
- Opcodes:
  - 0000: nop.
  - 0001-1101: ALU operations; the opcode is passed to alu_ctrl unchanged.
  - 1110: ldi, rd <= {8'h00, imm8}; the ALU is not used.
  - 1111: illegal.
- IDLE:
  - alu_ctrl=0000, in_ready=1.
  - On in_valid, at the clock edge: latch the instruction; alu_a<=rf[rs], alu_b<=rf[rt] (read from the in_instr fields); go to SETTLE.
- SETTLE:
  - One cycle; alu_ctrl stays 0000 so operands are stable one full cycle before control changes.
  - Next state is EXEC; alu_ctrl<=op for opcodes 0001-1101, otherwise it stays 0000.
- EXEC:
  - Held for exactly EXEC_CYCLES cycles, using an internal down-counter; alu_a, alu_b and alu_ctrl are held.
  - Then go to WB.
- WB:
  - One cycle, alu_ctrl still held.
  - At the edge ending WB:
    - op 0001-1101: rf[rd]<=alu_result.
    - ldi: write imm8 as above.
    - nop: no write.
    - Illegal: no write, err<=1, no retire pulse, retire_cnt unchanged.
    - All other opcodes: retire=1 during the WB cycle and retire_cnt increments at its end.
  - Next state is IDLE with alu_ctrl<=0000.
  - Returning to 0000 guarantees that two identical back-to-back opcodes still produce a control transition at the ALU.
- Latency and throughput:
  - Accept edge t; the write lands at edge t+2+EXEC_CYCLES.
  - The next accept is possible at edge t+3+EXEC_CYCLES; throughput is one instruction per 3+EXEC_CYCLES cycles.
  - The following instruction reads the updated register file (write completes before its IDLE accept edge).
- Handshake:
  - in_ready is low whenever busy.
  - in_valid/in_instr held during busy are ignored and accepted on the first IDLE cycle.
  - in_instr is don't-care when in_valid is low.
- err: cleared only by reset; later instructions still execute normally.

Test Plan:
- Reset -> every output equals its reset value, dbg_data=0 for all 16 addresses, in_ready=1.
- ldi r1,0x05; ldi r2,0x03; op 0001 rd=3 rs=1 rt=2 -> rf[3]=0x0008, retire_cnt=3; with EXEC_CYCLES=1, each write lands at accept edge+3.
- Two back-to-back op 0010 (rd=4 and rd=5, rs=1, rt=2) -> alu_ctrl sequence 0000,0010,0010,0000,0000,0010,...; rf[4]=rf[5]=0x0002.
- ldi r0,0xFF, then op 0001 rd=6 rs=0 rt=1 -> rf[0] reads 0, rf[6]=0x0005.
- op 1111 -> err=1 sticky, no register changes, no retire pulse; a following ldi r7,0x11 still retires and rf[7]=0x0011.
- in_valid held high for 10 cycles -> accepts exactly at IDLE cycles, in_ready=0 while busy; rst_n low mid-EXEC -> immediate IDLE, alu_ctrl=0000, target register stays 0.
